// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    PH_DEAD  = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_LUT[hex];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-slot dead time.
// Leading-zero blanking is compiled in when SEG7_SCAN_LZB_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            SEG,
  output logic                  frame
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shd_q, shd_d;
  logic [DIGITS-1:0]   an_q, an_d;
  seg_t                seg_q, seg_d;
  logic                frame_q, frame_d;

  logic [3:0] nibble;
  seg_t       seg_hex;
  logic       blank;
  logic       slot_end;
  phase_e     phase;

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      always_comb phase = PH_DRIVE;
    end else begin : g_dead
      always_comb phase = (cnt_q < CNT_W'(DEAD_CYCLES)) ? PH_DEAD : PH_DRIVE;
    end
  endgenerate

  always_comb begin
    nibble = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) nibble = shd_q[4*i +: 4];
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  logic [DIGITS-1:0] nz_above;

  // nz_above[i] is set when any nibble at position i or higher is non-zero.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    nz_above = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      acc                       = acc | (|shd_q[4*(DIGITS-1-k) +: 4]);
      nz_above[DIGITS-1-k]      = acc;
    end
    blank = (idx_q != '0) && !nz_above[idx_q];
  end
`else
  always_comb blank = 1'b0;
`endif

  seg7_hex_decoder u_dec (
    .hex (nibble),
    .seg (seg_hex)
  );

  // Output registers are fed from the current (pre-edge) cnt/idx/shd.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shd_d    = load ? value : shd_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    an_d = '1;
    if (phase == PH_DRIVE && !blank) an_d[idx_q] = 1'b0;
    seg_d   = blank ? SEG_BLANK : seg_hex;
    frame_d = slot_end && (idx_q == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shd_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shd_q   <= shd_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign AN    = an_q;
  assign SEG   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a 4-digit and a 1-digit instance
// are compared cycle by cycle against a time-based reference model.
module tb_seg7_scan_driver;

  localparam int D0 = 4, RD0 = 8, DC0 = 2;
  localparam int D1 = 1, RD1 = 2, DC1 = 0;

  localparam logic [6:0] ENC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       frame;
  } out_t;

  typedef struct packed {
    out_t o0;
    out_t o1;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  an0;
  logic [6:0]  seg0;
  logic        frame0;
  logic [0:0]  an1;
  logic [6:0]  seg1;
  logic        frame1;

  item_t sbq[$];
  int    checks = 0;
  int    errors = 0;

  // Model state: edges since reset release and the captured display values.
  int          j = 0;
  logic [15:0] shd0 = '0;
  logic [3:0]  shd1 = '0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(D0), .REFRESH_DIV(RD0), .DEAD_CYCLES(DC0)) dut0 (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .AN(an0), .SEG(seg0), .frame(frame0)
  );

  seg7_scan_driver #(.DIGITS(D1), .REFRESH_DIV(RD1), .DEAD_CYCLES(DC1)) dut1 (
    .clk(clk), .reset(reset), .value(value[3:0]), .load(load),
    .AN(an1), .SEG(seg1), .frame(frame1)
  );

  function automatic out_t model(int d, int rd, int dc, int t, logic [31:0] shd, bit rst);
    out_t o;
    int cnt, idx, nib;
    bit blanked;
    if (rst) begin
      o.an = 8'hFF; o.seg = 7'h7F; o.frame = 1'b0;
      return o;
    end
    cnt = t % rd;
    idx = (t / rd) % d;
    nib = int'((shd >> (4*idx)) & 32'hF);
    blanked = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
    blanked = (idx > 0) && ((shd >> (4*idx)) == 0);
`endif
    o.an    = (cnt < dc || blanked) ? 8'hFF : ~(8'd1 << idx);
    o.seg   = blanked ? 7'h7F : ENC[nib];
    o.frame = ((t + 1) % (d * rd)) == 0;
    return o;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle; at the edge, push the expected registered outputs.
  task automatic cyc(input logic r, input logic l, input logic [15:0] v);
    item_t it;
    @(negedge clk);
    reset = r; load = l; value = v;
    @(posedge clk);
    it.o0 = model(D0, RD0, DC0, j, {16'h0, shd0}, r);
    it.o1 = model(D1, RD1, DC1, j, {28'h0, shd1}, r);
    sbq.push_back(it);
    if (r) begin
      j = 0; shd0 = '0; shd1 = '0;
    end else begin
      j++;
      if (l) begin shd0 = v; shd1 = v[3:0]; end
    end
  endtask

  initial begin : monitor
    item_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("AN0",    {4'hF, an0},          e.o0.an);
        chk("SEG0",   {1'b0, seg0},         {1'b0, e.o0.seg});
        chk("FRAME0", {7'b0, frame0},       {7'b0, e.o0.frame});
        chk("AN1",    {7'b1111111, an1},    e.o1.an);
        chk("SEG1",   {1'b0, seg1},         {1'b0, e.o1.seg});
        chk("FRAME1", {7'b0, frame1},       {7'b0, e.o1.frame});
      end
    end
  end

  initial begin : stim
    logic [15:0] v;
    reset = 1'b1; load = 1'b0; value = '0;
    repeat (3) cyc(1'b1, 1'b0, 16'h0);
    repeat (10) cyc(1'b0, 1'b0, 16'h0);

    // Scan order with 1234, then a load of FFFF inside digit 1's drive phase.
    cyc(1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'h1234);
    while (j != 12) cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'hFFFF);
    repeat (40) cyc(1'b0, 1'b0, 16'h0);

    // Reset while idx=2, cnt=5.
    cyc(1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'h1234);
    while (j != 21) cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0);
    repeat (40) cyc(1'b0, 1'b0, 16'h0);

    // Leading-zero patterns.
    cyc(1'b0, 1'b1, 16'h00A5);
    repeat (40) cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'h0000);
    repeat (40) cyc(1'b0, 1'b0, 16'h0);

    // Live tracking with load held high.
    for (int i = 0; i < 80; i++) cyc(1'b0, 1'b1, 16'($urandom));

    // Random loads of varying magnitude plus occasional resets.
    for (int i = 0; i < 2000; i++) begin
      v = 16'($urandom) >> $urandom_range(0, 16);
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0), v);
    end

    @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL SBQ_DRAIN: actual=%0d required=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
